pmt_upper_decom: RTL
====================

# pmt_upper_decom

Streaming inverse lane permutation for the radix-4 FFT datapath. Upstream, the upper permutation stage rotates four complex lanes (a, b, c, d) by an amount that steps through 0, 1, 2, 3. That stepping follows its gray-code select sequence 00→01→11→10. This block is the receiving end of that rotation: it tracks the rotation from the frame-start control pulse and undoes it, restoring natural lane order. Output is registered, with one cycle of latency and a valid/ctrl sideband.

## Interface
- DATA_WIDTH, 16: width of each real or imaginary word.
- PROBLEM_SIZE, 16: FFT size N (16, 64, 256).
- PER_DISTANCE, PROBLEM_SIZE/16: number of accepted words between rotation steps.
- WIDTH_COUNTER, 1: word-counter width; must be ≥ max(1, clog2(PER_DISTANCE)).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- valid_in  in  1  input word present this cycle.
- ctrl_in  in  1  frame start; only meaningful when valid_in=1.
- x_a_in, y_a_in, x_b_in, y_b_in, x_c_in, y_c_in, x_d_in, y_d_in  in  DATA_WIDTH each  rotated lanes (x = real part, y = imaginary part).
- x_a_out … y_d_out  out  DATA_WIDTH each  lanes restored to natural order, registered.
- valid_out  out  1  valid_in delayed 1 cycle.
- ctrl_out  out  1  (ctrl_in & valid_in) delayed 1 cycle.
- rot_out  out  2  rotation amount r that was undone on the current output word.

## Operation
- Lane index: a=0, b=1, c=2, d=3. Each lane is a complex pair {x, y}; x and y always move together.
- Undo rule for rotation r: out[k] = in[(k + r) mod 4].
  - Upstream applied up[k] = orig[k − r], so this rule recovers orig[k].
- Internal state:
  - started: 1 bit.
  - cnt: WIDTH_COUNTER bits.
  - r: 2 bits, held as a binary rotation count, not in gray code.
- Rotation used for an accepted word, in priority order:
  - If valid_in & ctrl_in: r_use = 0.
  - Else if started: r_use = r.
  - Else: r_use = 0.
- State update on each accepted word (valid_in=1):
  - With ctrl_in=1: started←1. If PER_DISTANCE=1, r←1 and cnt←0. Otherwise r←0 and cnt←1.
  - With ctrl_in=0 and started=1: if cnt = PER_DISTANCE−1, then cnt←0 and r←r+1 (mod 4); otherwise cnt←cnt+1.
  - With ctrl_in=0 and started=0: state unchanged; the word passes through with r_use=0.
- Net effect: the n-th accepted word after a ctrl word (the ctrl word itself is n=0) is undone with r = floor(n/PER_DISTANCE) mod 4.
- valid_in=0: state frozen. Data outputs hold their previous value; valid_out←0 and ctrl_out←0.
- ctrl_in while already started: the frame restarts immediately. The ctrl word uses r=0 and the counters reload as above.
- r wraps 3→0 with no special action; frames longer than 4·PER_DISTANCE words simply keep cycling.
- ctrl_in with valid_in=0 is ignored.

## Timing
- Latency: 1 cycle. An input sampled at edge t appears on the outputs after edge t. rot_out shows the r_use of that same word.
- Throughput: one word per cycle; no backpressure.
- Reset: if rst=1 at an edge, then
  - all data outputs, valid_out, ctrl_out, rot_out ← 0;
  - started←0, cnt←0, r←0.
- rst takes priority over valid_in and ctrl_in in the same cycle.
- rst mid-frame drops the frame. Words after reset pass through with r=0 until the next ctrl_in.

## Test plan
- Reset: hold rst for 2 cycles with random inputs → every output is 0 on both cycles. On the first valid cycle after reset without ctrl_in, the data passes through unchanged and rot_out=0.
- PER_DISTANCE=1, in these vectors x_a..x_d = (A, B, C, D) and y = x + 16:
  - ctrl word (1, 2, 3, 4) → (1, 2, 3, 4), rot 0.
  - Then (4, 1, 2, 3) → (1, 2, 3, 4), rot 1.
  - Then (3, 4, 1, 2) → (1, 2, 3, 4), rot 2.
  - Then (2, 3, 4, 1) → (1, 2, 3, 4), rot 3.
  - Then (1, 2, 3, 4) → (1, 2, 3, 4), rot 0 (wrap).
  - ctrl_out is high only on the first output.
- PROBLEM_SIZE=64 (PER_DISTANCE=4): 20 consecutive valid words after ctrl → rot_out sequence 0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0,0,0.
- Gaps, PER_DISTANCE=2: valid pattern 1,0,1,1,0,0,1 starting with ctrl → rot_out on the valid outputs 0,0,1,1. The invalid cycles have valid_out=0 and the data outputs hold.
- Restart and reset mid-frame:
  - ctrl_in on the 3rd word of a frame (PER_DISTANCE=1) → that word uses rot 0 and the next word uses rot 1.
  - rst on the 3rd word → outputs 0; the following valid non-ctrl word uses rot 0.
- Randomized: 4 frames of random data pre-rotated by a reference model of the upstream rotation (PER_DISTANCE=16) → outputs equal the original words, with a 1-cycle lag.

Source files
------------

// File: rtl/pmt_upper_decom.sv
// pmt_upper_decom
// ----------------------------------------------------------------------------
// Receiving end of the radix-4 FFT upper permutation stage. Upstream rotates
// the four complex lanes (a, b, c, d) by an amount r that advances by one
// every PER_DISTANCE accepted words after a frame-start (ctrl) word. This
// block tracks r from the ctrl pulse and undoes it, so that
//   out[k] = in[(k + r) mod 4]
// which restores natural lane order. Outputs are registered, so latency is
// one cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   valid_in   input word present this cycle
//   ctrl_in    frame start; only meaningful together with valid_in
//   x_*_in     real parts of the rotated lanes a..d
//   y_*_in     imaginary parts of the rotated lanes a..d
//   x_*_out    real parts restored to natural order (registered)
//   y_*_out    imaginary parts restored to natural order (registered)
//   valid_out  valid_in delayed one cycle
//   ctrl_out   (ctrl_in & valid_in) delayed one cycle
//   rot_out    rotation amount undone on the current output word
//
// Handshake: valid_in qualifies every input word. There is no backpressure;
// a word presented with valid_in=1 is always accepted, and valid_out marks
// the cycle its restored copy appears on the outputs. While valid_in=0 the
// data outputs and rot_out hold their previous values.
// ----------------------------------------------------------------------------
module pmt_upper_decom #(
    parameter int DATA_WIDTH    = 16,
    parameter int PROBLEM_SIZE  = 16,
    parameter int PER_DISTANCE  = PROBLEM_SIZE / 16,
    parameter int WIDTH_COUNTER = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic                  ctrl_in,
    input  logic [DATA_WIDTH-1:0] x_a_in,
    input  logic [DATA_WIDTH-1:0] y_a_in,
    input  logic [DATA_WIDTH-1:0] x_b_in,
    input  logic [DATA_WIDTH-1:0] y_b_in,
    input  logic [DATA_WIDTH-1:0] x_c_in,
    input  logic [DATA_WIDTH-1:0] y_c_in,
    input  logic [DATA_WIDTH-1:0] x_d_in,
    input  logic [DATA_WIDTH-1:0] y_d_in,
    output logic [DATA_WIDTH-1:0] x_a_out,
    output logic [DATA_WIDTH-1:0] y_a_out,
    output logic [DATA_WIDTH-1:0] x_b_out,
    output logic [DATA_WIDTH-1:0] y_b_out,
    output logic [DATA_WIDTH-1:0] x_c_out,
    output logic [DATA_WIDTH-1:0] y_c_out,
    output logic [DATA_WIDTH-1:0] x_d_out,
    output logic [DATA_WIDTH-1:0] y_d_out,
    output logic                  valid_out,
    output logic                  ctrl_out,
    output logic [1:0]            rot_out
);

    localparam logic [WIDTH_COUNTER-1:0] CNT_LAST = WIDTH_COUNTER'(PER_DISTANCE - 1);

    // Tracking state. r_rot is a plain binary rotation count (the upstream
    // gray-code select is only its encoding of the same 0,1,2,3 walk).
    logic                     r_started;
    logic [WIDTH_COUNTER-1:0] r_cnt;
    logic [1:0]               r_rot;

    // Registered outputs
    logic [DATA_WIDTH-1:0] r_x_out [4];
    logic [DATA_WIDTH-1:0] r_y_out [4];
    logic                  r_valid_out;
    logic                  r_ctrl_out;
    logic [1:0]            r_rot_out;

    logic [DATA_WIDTH-1:0] w_x_in  [4];
    logic [DATA_WIDTH-1:0] w_y_in  [4];
    logic [DATA_WIDTH-1:0] w_x_res [4];
    logic [DATA_WIDTH-1:0] w_y_res [4];
    logic [1:0]            w_r_use;

    assign w_x_in[0] = x_a_in;
    assign w_x_in[1] = x_b_in;
    assign w_x_in[2] = x_c_in;
    assign w_x_in[3] = x_d_in;
    assign w_y_in[0] = y_a_in;
    assign w_y_in[1] = y_b_in;
    assign w_y_in[2] = y_c_in;
    assign w_y_in[3] = y_d_in;

    // A ctrl word always starts a fresh frame at rotation 0, even when a
    // frame is already running; before the first ctrl words pass straight.
    always_comb begin
        w_r_use = 2'd0;
        if (valid_in && ctrl_in) begin
            w_r_use = 2'd0;
        end else if (r_started) begin
            w_r_use = r_rot;
        end
    end

    // Inverse rotation: lane k takes input lane (k + r) mod 4, x and y
    // moving together. The 2-bit add wraps the index for free.
    always_comb begin
        logic [1:0] src;
        src = 2'd0;
        for (int k = 0; k < 4; k++) begin
            src        = 2'(k) + w_r_use;
            w_x_res[k] = w_x_in[src];
            w_y_res[k] = w_y_in[src];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_started   <= 1'b0;
            r_cnt       <= '0;
            r_rot       <= 2'd0;
            r_valid_out <= 1'b0;
            r_ctrl_out  <= 1'b0;
            r_rot_out   <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                r_x_out[k] <= '0;
                r_y_out[k] <= '0;
            end
        end else begin
            r_valid_out <= valid_in;
            r_ctrl_out  <= valid_in & ctrl_in;
            if (valid_in) begin
                r_rot_out <= w_r_use;
                for (int k = 0; k < 4; k++) begin
                    r_x_out[k] <= w_x_res[k];
                    r_y_out[k] <= w_y_res[k];
                end
                if (ctrl_in) begin
                    r_started <= 1'b1;
                    // The ctrl word itself is word 0 of step 0. With one
                    // word per step the next word already belongs to step 1.
                    if (PER_DISTANCE == 1) begin
                        r_rot <= 2'd1;
                        r_cnt <= '0;
                    end else begin
                        r_rot <= 2'd0;
                        r_cnt <= WIDTH_COUNTER'(1);
                    end
                end else if (r_started) begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        r_rot <= r_rot + 2'd1;
                    end else begin
                        r_cnt <= r_cnt + WIDTH_COUNTER'(1);
                    end
                end
            end
        end
    end

    assign x_a_out   = r_x_out[0];
    assign x_b_out   = r_x_out[1];
    assign x_c_out   = r_x_out[2];
    assign x_d_out   = r_x_out[3];
    assign y_a_out   = r_y_out[0];
    assign y_b_out   = r_y_out[1];
    assign y_c_out   = r_y_out[2];
    assign y_d_out   = r_y_out[3];
    assign valid_out = r_valid_out;
    assign ctrl_out  = r_ctrl_out;
    assign rot_out   = r_rot_out;

endmodule
